// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use bubbles, MEM-resolved
// branch redirects, multi-cycle data-memory waits with timeout, and saturating counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memtoRead,
    input  logic [4:0]       ex_rd,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             mem_memRead,
    input  logic             mem_memWrite,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             pc_sel_branch,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             bus_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [7:0]       TIMEOUT = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       mem_acc;
    logic       taken;
    logic       load_use;
    logic       mem_stall;

    assign mem_acc   = mem_memRead | mem_memWrite;
    assign taken     = mem_branch & mem_zero;
    assign mem_stall = mem_acc & ~dmem_ready;
    assign load_use  = ex_memtoRead & (ex_rd != 5'd0) &
                       ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

    // Priority: reset > halt > memory wait > taken branch > load-use.
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        dmem_req      = 1'b0;
        pc_en         = 1'b1;
        pc_sel_branch = 1'b0;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        memwb_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        memwb_flush   = 1'b0;
        if (rst) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en}             = '0;
            {ifid_flush, idex_flush, exmem_flush, memwb_flush}        = 4'b1111;
        end else if (state == HALT) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en}             = '0;
        end else begin
            dmem_req = mem_acc;
            if (mem_stall) begin
                {pc_en, ifid_en, idex_en, exmem_en} = '0;
                memwb_flush                         = 1'b1;
            end else if (taken) begin
                pc_sel_branch                       = 1'b1;
                {ifid_flush, idex_flush, exmem_flush} = 3'b111;
            end else if (load_use) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state        <= RUN;
            wait_cnt     <= '0;
            bus_error    <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (state != HALT && !pc_en && stall_cycles != CNT_MAX)
                stall_cycles <= stall_cycles + CNT_W'(1);
            // A branch held behind a memory wait is only counted once it is applied.
            if (state != HALT && taken && !mem_stall && flush_count != CNT_MAX)
                flush_count <= flush_count + CNT_W'(1);
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem_stall) begin
                        if (wait_cnt == TIMEOUT) begin
                            state     <= HALT;
                            bus_error <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end else begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end
                end
                HALT:    bus_error <= 1'b1;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the load-enable and flush (bubble-insert) controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB buffers.
- Handles load-use stalls, taken-branch redirects resolved in MEM, and multi-cycle data-memory accesses via a req/ready handshake with timeout.
- Keeps saturating performance counters.

Parameters:
- MEM_TIMEOUT, 15, max MEM_WAIT cycles before fatal bus error (range 1..255).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- id_rs  in  5  rs of instruction in ID.
- id_rt  in  5  rt of instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_memtoRead  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of instruction in EX.
- mem_branch  in  1  branch flag at EX/MEM output.
- mem_zero  in  1  zero flag at EX/MEM output.
- mem_memRead  in  1  load in MEM stage.
- mem_memWrite  in  1  store in MEM stage.
- dmem_ready  in  1  data memory completes the access this cycle.
- dmem_req  out  1  data memory access request.
- pc_en  out  1  PC load enable.
- pc_sel_branch  out  1  select the branch target for the PC.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  buffer load enables.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load zeros (bubble); a flush overrides the enable.
- bus_error  out  1  sticky timeout flag.
- stall_cycles  out  CNT_W  saturating stall counter.
- flush_count  out  CNT_W  saturating taken-branch counter.

Behaviour:
- State register: RUN=0, MEM_WAIT=1, HALT=2. Wait counter wait_cnt is 8 bits.
- All control outputs are combinational from state plus inputs. Counters, state and bus_error are registered.
- Terms:
  - mem_acc = mem_memRead | mem_memWrite.
  - taken = mem_branch & mem_zero.
  - load_use = ex_memtoRead & (ex_rd != 0) & (ex_rd == id_rs | (id_uses_rt & ex_rd == id_rt)).
- Default (no hazard): all enables 1, all flushes 0, pc_sel_branch 0.
- During rst:
  - Outputs: all enables 0, all flushes 1, dmem_req 0, pc_sel_branch 0.
  - Next state: RUN; wait_cnt, bus_error, stall_cycles and flush_count all cleared to 0.
  - rst mid-MEM_WAIT or in HALT returns to RUN next cycle.
- dmem_req = mem_acc & (state == RUN | state == MEM_WAIT).
- Priority in RUN and MEM_WAIT: memory wait > taken branch > load-use.
- Memory wait (mem_acc & !dmem_ready):
  - Freeze: pc_en, ifid_en, idex_en, exmem_en = 0; memwb_flush = 1.
  - From RUN: state <= MEM_WAIT, wait_cnt <= 1.
  - In MEM_WAIT: wait_cnt increments each cycle. When wait_cnt == MEM_TIMEOUT and dmem_ready is still 0: state <= HALT, bus_error <= 1.
- dmem_ready with mem_acc (in RUN: zero-latency, no stall):
  - Pipeline advances normally; state <= RUN, wait_cnt <= 0.
  - load_use is evaluated in the same cycle.
- Taken branch:
  - pc_sel_branch = 1, pc_en = 1.
  - ifid_flush, idex_flush, exmem_flush = 1; memwb_en = 1.
  - flush_count increments.
  - If taken and a memory wait are both active, the memory wait wins and the branch is held until the pipeline advances.
- Load-use (no higher-priority event):
  - pc_en = 0, ifid_en = 0, idex_flush = 1; exmem_en and memwb_en = 1.
  - Exactly one bubble, with no state change: the next cycle ex_memtoRead is 0.
- HALT:
  - All enables 0, all flushes 0, dmem_req 0.
  - bus_error held at 1; only rst exits.
- stall_cycles increments on every non-reset cycle with pc_en = 0 and state != HALT.
- Both counters saturate at all-ones and do not wrap.

Test Plan:
- Reset: assert rst for 2 cycles, release -> during rst all flushes 1 and enables 0; after release all enables 1, counters 0, state RUN.
- Load-use: ex_memtoRead=1, ex_rd=8, id_rs=8 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cycles=1. Repeat with ex_rd=0 -> no stall.
- Taken branch: mem_branch=1, mem_zero=1 -> pc_sel_branch=1, three flushes for 1 cycle, flush_count=1. Same with mem_zero=0 -> no action.
- Memory wait: mem_memRead=1, dmem_ready low for 3 cycles then high -> 3 frozen cycles with memwb_flush=1, then advance; dmem_req high all 4 cycles; stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, mem_memWrite=1, dmem_ready never -> HALT after the 4th wait cycle, bus_error=1 held. Then rst -> RUN, bus_error=0.
- Simultaneous: load_use on the cycle dmem_ready rises -> pipeline advances and the bubble is inserted in the same cycle. Counter saturation check with CNT_W=4: 20 stalls -> stall_cycles=15.
